// File: rtl/pipelined_control_unit.sv
// RISC-8 decode-stage control: opcode decode, load-use hazard detection and
// the ID/EX control register, with saturating bubble/illegal debug counters.
module pipelined_control_unit #(
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned REG_W    = 3,
   parameter int unsigned ALUOP_W  = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [OPCODE_W-1:0] id_opcode,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                flush,
   output logic                stall,
   output logic                ex_regwrite,
   output logic                ex_memread,
   output logic                ex_memwrite,
   output logic                ex_memtoreg,
   output logic                ex_alusrc,
   output logic                ex_branch,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [REG_W-1:0]    ex_rd,
   output logic                ex_valid,
   output logic                illegal,
   output logic [CNT_W-1:0]    bubble_cnt,
   output logic [CNT_W-1:0]    illegal_cnt
);

   logic [3:0]         op_lo;
   logic               upper_zero;
   logic               dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg;
   logic               dec_alusrc, dec_branch, dec_illegal;
   logic               uses_rs1, uses_rs2;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               hazard;

   logic               ex_regwrite_q, ex_memread_q, ex_memwrite_q, ex_memtoreg_q;
   logic               ex_alusrc_q, ex_branch_q, ex_valid_q, illegal_q;
   logic [ALUOP_W-1:0] ex_aluop_q;
   logic [REG_W-1:0]   ex_rd_q;
   logic [CNT_W-1:0]   bubble_cnt_q, illegal_cnt_q;

   logic               ex_regwrite_d, ex_memread_d, ex_memwrite_d, ex_memtoreg_d;
   logic               ex_alusrc_d, ex_branch_d, ex_valid_d, illegal_d;
   logic [ALUOP_W-1:0] ex_aluop_d;
   logic [REG_W-1:0]   ex_rd_d;
   logic [CNT_W-1:0]   bubble_cnt_d, illegal_cnt_d;

   assign op_lo      = id_opcode[3:0];
   assign upper_zero = ((id_opcode >> 4) == '0);

   // Opcode decode; illegal opcodes decode as NOP with no source usage.
   always_comb begin : decode
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      dec_memtoreg = 1'b0;
      dec_alusrc   = 1'b0;
      dec_branch   = 1'b0;
      dec_aluop    = '0;
      dec_illegal  = 1'b0;
      uses_rs1     = 1'b0;
      uses_rs2     = 1'b0;
      if (upper_zero) begin
         case (op_lo)
            4'h0, 4'h1, 4'h2, 4'h3: begin
               dec_regwrite = 1'b1;
               dec_aluop    = ALUOP_W'(op_lo);
               uses_rs1     = 1'b1;
               uses_rs2     = 1'b1;
            end
            4'h4: begin
               dec_regwrite = 1'b1;
               dec_alusrc   = 1'b1;
               uses_rs1     = 1'b1;
            end
            4'h5: begin
               dec_regwrite = 1'b1;
               dec_memread  = 1'b1;
               dec_memtoreg = 1'b1;
               dec_alusrc   = 1'b1;
               uses_rs1     = 1'b1;
            end
            4'h6: begin
               dec_memwrite = 1'b1;
               dec_alusrc   = 1'b1;
               uses_rs1     = 1'b1;
               uses_rs2     = 1'b1;
            end
            4'h7: begin
               dec_branch   = 1'b1;
               dec_aluop    = ALUOP_W'(4'd1);
               uses_rs1     = 1'b1;
               uses_rs2     = 1'b1;
            end
            4'hF: ;
            default: dec_illegal = 1'b1;
         endcase
      end else begin
         dec_illegal = 1'b1;
      end
   end

   // Load-use hazard against the load currently in EX; flush wins over stall.
   assign hazard = id_valid & ex_valid_q & ex_memread_q &
                   ((uses_rs1 & (id_rs1 == ex_rd_q)) | (uses_rs2 & (id_rs2 == ex_rd_q)));
   assign stall  = hazard & ~flush;

   always_comb begin : next_state
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_memwrite_d = 1'b0;
      ex_memtoreg_d = 1'b0;
      ex_alusrc_d   = 1'b0;
      ex_branch_d   = 1'b0;
      ex_aluop_d    = '0;
      ex_rd_d       = '0;
      ex_valid_d    = 1'b0;
      illegal_d     = 1'b0;
      bubble_cnt_d  = bubble_cnt_q;
      illegal_cnt_d = illegal_cnt_q;
      if (flush || stall) begin
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else if (id_valid) begin
         ex_regwrite_d = dec_regwrite;
         ex_memread_d  = dec_memread;
         ex_memwrite_d = dec_memwrite;
         ex_memtoreg_d = dec_memtoreg;
         ex_alusrc_d   = dec_alusrc;
         ex_branch_d   = dec_branch;
         ex_aluop_d    = dec_aluop;
         ex_rd_d       = id_rd;
         ex_valid_d    = 1'b1;
         if (dec_illegal) begin
            illegal_d = 1'b1;
            if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_memwrite_q <= 1'b0;
         ex_memtoreg_q <= 1'b0;
         ex_alusrc_q   <= 1'b0;
         ex_branch_q   <= 1'b0;
         ex_aluop_q    <= '0;
         ex_rd_q       <= '0;
         ex_valid_q    <= 1'b0;
         illegal_q     <= 1'b0;
         bubble_cnt_q  <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ex_regwrite_q <= ex_regwrite_d;
         ex_memread_q  <= ex_memread_d;
         ex_memwrite_q <= ex_memwrite_d;
         ex_memtoreg_q <= ex_memtoreg_d;
         ex_alusrc_q   <= ex_alusrc_d;
         ex_branch_q   <= ex_branch_d;
         ex_aluop_q    <= ex_aluop_d;
         ex_rd_q       <= ex_rd_d;
         ex_valid_q    <= ex_valid_d;
         illegal_q     <= illegal_d;
         bubble_cnt_q  <= bubble_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign ex_regwrite = ex_regwrite_q;
   assign ex_memread  = ex_memread_q;
   assign ex_memwrite = ex_memwrite_q;
   assign ex_memtoreg = ex_memtoreg_q;
   assign ex_alusrc   = ex_alusrc_q;
   assign ex_branch   = ex_branch_q;
   assign ex_aluop    = ex_aluop_q;
   assign ex_rd       = ex_rd_q;
   assign ex_valid    = ex_valid_q;
   assign illegal     = illegal_q;
   assign bubble_cnt  = bubble_cnt_q;
   assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit; a second instance with 2-bit
// counters exercises saturation.
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       rst, id_valid, flush;
   logic [3:0] id_opcode;
   logic [2:0] id_rs1, id_rs2, id_rd;

   logic       stall, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch;
   logic [3:0] ex_aluop;
   logic [2:0] ex_rd;
   logic       ex_valid, illegal;
   logic [7:0] bubble_cnt, illegal_cnt;

   logic       s_stall, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc, s_branch;
   logic [3:0] s_aluop;
   logic [2:0] s_rd;
   logic       s_valid, s_illegal;
   logic [1:0] s_bubble_cnt, s_illegal_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipelined_control_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(stall), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
      .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .illegal(illegal), .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
   );

   pipelined_control_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(s_stall), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
      .ex_memwrite(s_memwrite), .ex_memtoreg(s_memtoreg), .ex_alusrc(s_alusrc),
      .ex_branch(s_branch), .ex_aluop(s_aluop), .ex_rd(s_rd), .ex_valid(s_valid),
      .illegal(s_illegal), .bubble_cnt(s_bubble_cnt), .illegal_cnt(s_illegal_cnt)
   );

   // {regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop}
   logic [9:0] ctl_obs;
   assign ctl_obs = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                     ex_alusrc, ex_branch, ex_aluop};

   function automatic logic [9:0] exp_ctl(input logic [3:0] op);
      case (op)
         4'h0:    return 10'b100000_0000;
         4'h1:    return 10'b100000_0001;
         4'h2:    return 10'b100000_0010;
         4'h3:    return 10'b100000_0011;
         4'h4:    return 10'b100010_0000;
         4'h5:    return 10'b110110_0000;
         4'h6:    return 10'b001010_0000;
         4'h7:    return 10'b000001_0001;
         default: return 10'b000000_0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd);
      id_valid  = 1'b1;
      id_opcode = op;
      id_rs1    = rs1;
      id_rs2    = rs2;
      id_rd     = rd;
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_ctl"}, 32'(ctl_obs), 32'd0);
      chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
      chk({tag, "_rd"}, 32'(ex_rd), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      id_valid = 1'b1; id_opcode = 4'h5; id_rs1 = 3'd0; id_rs2 = 3'd0; id_rd = 3'd0;

      // Reset held with a LW presented
      for (int i = 0; i < 2; i++) begin
         step();
         chk_bubble("rst");
         chk("rst_illegal", 32'(illegal), 32'd0);
         chk("rst_bcnt", 32'(bubble_cnt), 32'd0);
         chk("rst_icnt", 32'(illegal_cnt), 32'd0);
      end
      rst = 1'b0;
      step();
      chk("post_rst_lw", 32'(ctl_obs), 32'(exp_ctl(4'h5)));
      chk("post_rst_valid", 32'(ex_valid), 32'd1);
      drive(4'hF, 3'd0, 3'd0, 3'd0);
      chk("nop_stall", 32'(stall), 32'd0);
      step();

      // Decode sweep, no hazards (sources never match rd=7)
      for (int op = 0; op < 16; op++) begin
         drive(4'(op), 3'd0, 3'd0, 3'd7);
         chk("sweep_stall", 32'(stall), 32'd0);
         step();
         chk($sformatf("sweep_ctl_%0h", op), 32'(ctl_obs), 32'(exp_ctl(4'(op))));
         chk($sformatf("sweep_valid_%0h", op), 32'(ex_valid), 32'd1);
         chk($sformatf("sweep_rd_%0h", op), 32'(ex_rd), 32'd7);
         chk($sformatf("sweep_ill_%0h", op), 32'(illegal), 32'((op >= 8) && (op <= 14)));
      end
      chk("sweep_icnt", 32'(illegal_cnt), 32'd7);
      chk("sweep_sat_icnt", 32'(s_illegal_cnt), 32'd3);
      chk("sweep_bcnt", 32'(bubble_cnt), 32'd0);

      // Load-use on rs2
      drive(4'h5, 3'd0, 3'd0, 3'd3);
      step();
      drive(4'h0, 3'd2, 3'd3, 3'd4);
      chk("lu_stall", 32'(stall), 32'd1);
      step();
      chk_bubble("lu_bubble");
      chk("lu_bcnt", 32'(bubble_cnt), 32'd1);
      chk("lu_stall_drop", 32'(stall), 32'd0);
      step();
      chk("lu_add_ctl", 32'(ctl_obs), 32'(exp_ctl(4'h0)));
      chk("lu_add_rd", 32'(ex_rd), 32'd4);
      chk("lu_add_valid", 32'(ex_valid), 32'd1);

      // ADDI ignores rs2
      drive(4'h5, 3'd0, 3'd0, 3'd3);
      step();
      drive(4'h4, 3'd2, 3'd3, 3'd5);
      chk("addi_stall", 32'(stall), 32'd0);
      step();
      chk("addi_ctl", 32'(ctl_obs), 32'(exp_ctl(4'h4)));

      // Store in EX does not cause a hazard
      drive(4'h6, 3'd0, 3'd0, 3'd3);
      step();
      drive(4'h0, 3'd3, 3'd0, 3'd5);
      chk("sw_stall", 32'(stall), 32'd0);
      step();
      chk("sw_add_ctl", 32'(ctl_obs), 32'(exp_ctl(4'h0)));

      // Register 0 still hazards
      drive(4'h5, 3'd1, 3'd1, 3'd0);
      step();
      drive(4'h0, 3'd0, 3'd1, 3'd2);
      chk("r0_stall", 32'(stall), 32'd1);
      step();
      chk("r0_bcnt", 32'(bubble_cnt), 32'd2);
      step();

      // Flush overrides stall
      drive(4'h5, 3'd0, 3'd0, 3'd1);
      step();
      drive(4'h0, 3'd1, 3'd0, 3'd2);
      flush = 1'b1;
      #1;
      chk("fl_stall", 32'(stall), 32'd0);
      step();
      flush = 1'b0;
      chk_bubble("fl_bubble");
      chk("fl_bcnt", 32'(bubble_cnt), 32'd3);

      // id_valid low loads a bubble, counters unchanged
      id_valid = 1'b0;
      step();
      chk_bubble("idle");
      chk("idle_bcnt", 32'(bubble_cnt), 32'd3);
      chk("idle_icnt", 32'(illegal_cnt), 32'd7);

      // Reset mid-stall
      drive(4'h5, 3'd0, 3'd0, 3'd2);
      step();
      drive(4'h0, 3'd2, 3'd0, 3'd3);
      chk("mrst_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_bubble("mrst");
      chk("mrst_bcnt", 32'(bubble_cnt), 32'd0);
      chk("mrst_stall_drop", 32'(stall), 32'd0);

      // Saturation: five flushes
      drive(4'hF, 3'd0, 3'd0, 3'd0);
      flush = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk($sformatf("sat_cnt_%0d", i), 32'(s_bubble_cnt), 32'((i < 3) ? i : 3));
         chk($sformatf("wide_cnt_%0d", i), 32'(bubble_cnt), 32'(i));
      end
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Decode-stage control for the RISC-8 pipeline, generalised from the purely combinational opcode decoder. Decodes the ID-stage opcode, detects load-use hazards against the instruction currently in EX, and registers the control bundle into the ID/EX pipeline register. Inserts bubbles on stall or flush, reports illegal opcodes, and keeps saturating bubble/illegal counters for debug.

Parameters:
OPCODE_W, 4, opcode width; decode table below uses the low 4 bits, upper bits must be zero or the opcode is illegal
REG_W, 3, register-address width
ALUOP_W, 4, ALU operation code width
CNT_W, 8, width of saturating debug counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  OPCODE_W  opcode in ID
id_rs1  in  REG_W  source register 1
id_rs2  in  REG_W  source register 2
id_rd  in  REG_W  destination register
flush  in  1  branch resolved taken; kill the instruction in ID
stall  out  1  combinational; freeze PC and IF/ID this cycle
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1 each  registered ID/EX controls
ex_aluop  out  ALUOP_W  registered ALU op
ex_rd  out  REG_W  registered destination
ex_valid  out  1  ID/EX holds a real (non-bubble) instruction
illegal  out  1  registered one-cycle pulse: the previous cycle's accepted instruction was illegal
bubble_cnt  out  CNT_W  bubbles inserted (stall or flush), saturates at all-ones
illegal_cnt  out  CNT_W  illegal opcodes seen, saturates

Behaviour:
- Decode (combinational, id_valid=1):
  - 0 ADD, 1 SUB, 2 AND, 3 OR: regwrite=1, aluop=opcode; uses rs1 and rs2.
  - 4 ADDI: regwrite=1, alusrc=1, aluop=0; uses rs1.
  - 5 LW: regwrite, memread, memtoreg, alusrc = 1; aluop=0; uses rs1.
  - 6 SW: memwrite=1, alusrc=1, aluop=0; uses rs1 and rs2.
  - 7 BEQ: branch=1, aluop=1 (SUB); uses rs1 and rs2.
  - F NOP: all controls 0; uses no sources.
  - 8-E, or any non-zero upper bit: illegal. Controls 0, treated as NOP. Uses no sources.
- Hazard detection:
  - hazard = id_valid & ex_valid & ex_memread & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
  - stall = hazard & ~flush.
- Per-cycle ID/EX update, in priority order:
  1. rst: all ex_* = 0, ex_valid=0, illegal=0, both counters 0.
  2. flush: load bubble (all controls 0, ex_valid=0, ex_rd=0). bubble_cnt++ . Any hazard is ignored.
  3. stall: load bubble. bubble_cnt++ . The same instruction re-presents next cycle.
  4. id_valid: load decoded controls, ex_rd=id_rd, ex_valid=1. If the opcode is illegal: illegal=1 and illegal_cnt++.
  5. Otherwise (id_valid=0): load bubble; counters unchanged.
- illegal is 0 in every cycle not covered by case 4 with an illegal opcode.
- Latency: 1 cycle from ID inputs to ex_* outputs. stall has 0 latency.
- Counters hold at 2^CNT_W-1; no wrap.
- A stalled instruction is re-decoded next cycle. At that point ex holds a bubble, so at most one stall cycle occurs per load-use.
- Reset mid-stall clears ID/EX, so stall drops in the following cycle.
- Register 0 has no special meaning: a hazard on rd=0 still stalls.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1, opcode 5 -> all ex_* = 0, ex_valid=0, counters 0 throughout; first post-reset edge loads LW controls.
- Full decode sweep: opcodes 0-F, no hazards -> ex_* match the table one cycle later. Opcodes 8-E pulse illegal each time, illegal_cnt=7, ex_valid=1 with zero controls.
- Load-use: LW rd=3, then ADD rs1=2 rs2=3 -> stall=1 for exactly one cycle, one bubble (bubble_cnt=1), ADD reaches ex on the following edge.
- No false hazard:
  - LW rd=3 then ADDI rs1=2 rs2=3 -> no stall (rs2 unused).
  - SW rd=3 then ADD rs1=3 -> no stall (ex_memread=0).
- Flush overrides stall: LW rd=1, then ADD rs1=1 with flush=1 the same cycle -> stall=0, bubble loaded, bubble_cnt=1.
- Saturation: CNT_W=2, force 5 flushes -> bubble_cnt sequence 1,2,3,3,3.
